// File: rtl/y86_decode_issue.sv
// Decode/writeback front end of the sequential Y86 core: register file, operand issue over
// the d_com/e_com handshake with the ALU, and writeback of valE.
module y86_decode_issue #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [63:0] valC,
   output logic [3:0]  alu_icode,
   output logic [3:0]  alu_ifun,
   output logic [63:0] alu_valA,
   output logic [63:0] alu_valB,
   output logic [63:0] alu_valC,
   output logic        d_com,
   input  logic [63:0] valE,
   input  logic        cnd,
   input  logic        e_com,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        halted,
   input  logic [3:0]  dbg_reg,
   output logic [63:0] dbg_val
);

   localparam int unsigned W      = 64;
   localparam int unsigned NREG   = 15;
   localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] R_NONE  = 4'hF;

   logic [W-1:0]     regs [NREG];
   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       dest, dest_nx;
   logic             is_cmov, is_cmov_nx;
   logic [W-1:0]     val_e_q, val_e_nx;
   logic             cnd_q, cnd_nx;
   logic [3:0]       alu_icode_nx, alu_ifun_nx;
   logic [W-1:0]     alu_val_a_nx, alu_val_b_nx, alu_val_c_nx;
   logic             d_com_nx, busy_nx, done_nx, err_nx, halted_nx;
   logic [W-1:0]     rd_a_c, rd_b_c;
   logic             wr_en_c;

   // Register file read ports; id 0xF decodes to no register and reads 0.
   always_comb begin
      rd_a_c  = '0;
      rd_b_c  = '0;
      dbg_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rA == 4'(i))      rd_a_c  = regs[i];
         if (rB == 4'(i))      rd_b_c  = regs[i];
         if (dbg_reg == 4'(i)) dbg_val = regs[i];
      end
   end

   assign wr_en_c = (state == S_WB) && (dest != R_NONE) && (!is_cmov || cnd_q);

   // Writeback port; retiring into 0xF never matches an entry, so the write is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en_c) begin
         for (int i = 0; i < NREG; i++) begin
            if (dest == 4'(i)) regs[i] <= val_e_q;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         dest      <= R_NONE;
         is_cmov   <= 1'b0;
         val_e_q   <= '0;
         cnd_q     <= 1'b0;
         alu_icode <= '0;
         alu_ifun  <= '0;
         alu_valA  <= '0;
         alu_valB  <= '0;
         alu_valC  <= '0;
         d_com     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         dest      <= dest_nx;
         is_cmov   <= is_cmov_nx;
         val_e_q   <= val_e_nx;
         cnd_q     <= cnd_nx;
         alu_icode <= alu_icode_nx;
         alu_ifun  <= alu_ifun_nx;
         alu_valA  <= alu_val_a_nx;
         alu_valB  <= alu_val_b_nx;
         alu_valC  <= alu_val_c_nx;
         d_com     <= d_com_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         err       <= err_nx;
         halted    <= halted_nx;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      dest_nx      = dest;
      is_cmov_nx   = is_cmov;
      val_e_nx     = val_e_q;
      cnd_nx       = cnd_q;
      alu_icode_nx = alu_icode;
      alu_ifun_nx  = alu_ifun;
      alu_val_a_nx = alu_valA;
      alu_val_b_nx = alu_valB;
      alu_val_c_nx = alu_valC;
      d_com_nx     = d_com;
      done_nx      = 1'b0;
      err_nx       = 1'b0;
      halted_nx    = halted;

      case (state)
         S_IDLE: begin
            if (start && !halted) begin
               case (icode)
                  I_OPQ, I_CMOV, I_IRMOV: begin
                     alu_icode_nx = icode;
                     alu_ifun_nx  = ifun;
                     alu_val_a_nx = (icode == I_IRMOV) ? '0 : rd_a_c;
                     alu_val_b_nx = (icode == I_OPQ) ? rd_b_c : '0;
                     alu_val_c_nx = valC;
                     dest_nx      = rB;
                     is_cmov_nx   = (icode == I_CMOV);
                     cnt_nx       = '0;
                     d_com_nx     = 1'b1;
                     state_nx     = S_WAIT;
                  end
                  I_NOP:   done_nx = 1'b1;
                  I_HALT: begin
                     done_nx   = 1'b1;
                     halted_nx = 1'b1;
                  end
                  default: err_nx = 1'b1;
               endcase
            end
         end
         S_WAIT: begin
            // A completion on the last allowed cycle still wins over the timeout.
            if (e_com) begin
               val_e_nx = valE;
               cnd_nx   = cnd;
               d_com_nx = 1'b0;
               done_nx  = 1'b1;
               state_nx = S_WB;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               d_com_nx = 1'b0;
               err_nx   = 1'b1;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_WB: begin
            state_nx = S_IDLE;
         end
         default: begin
            d_com_nx = 1'b0;
            state_nx = S_IDLE;
         end
      endcase

      busy_nx = (state_nx != S_IDLE);
   end

endmodule

// File: tb/tb_y86_decode_issue.sv
// Scoreboard bench for y86_decode_issue: stimulus queues expected ALU transactions and
// retire/error events, a negedge monitor pops and compares them as the DUT presents them.
module tb_y86_decode_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC;
   logic [3:0]  alu_icode, alu_ifun;
   logic [63:0] alu_valA, alu_valB, alu_valC;
   logic        d_com;
   logic [63:0] valE;
   logic        cnd, e_com;
   logic        busy, done, err, halted;
   logic [3:0]  dbg_reg;
   logic [63:0] dbg_val;

   y86_decode_issue #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
      .rA(rA), .rB(rB), .valC(valC), .alu_icode(alu_icode), .alu_ifun(alu_ifun),
      .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_valC(alu_valC), .d_com(d_com),
      .valE(valE), .cnd(cnd), .e_com(e_com), .busy(busy), .done(done), .err(err),
      .halted(halted), .dbg_reg(dbg_reg), .dbg_val(dbg_val)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ic;
      logic [3:0]  fn;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
   } alu_t;

   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   alu_t exp_alu[$];
   int   exp_evt[$];
   int   total = 0;
   int   bad   = 0;
   logic d_com_q = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare ALU transactions on d_com rising, and retire/error pulses.
   always @(negedge clk) begin
      alu_t e;
      int   ev;
      if (!rst_n) begin
         d_com_q = 1'b0;
      end else begin
         if (d_com && !d_com_q) begin
            if (exp_alu.size() == 0) begin
               check("alu_unexpected", 64'(d_com), 64'd0);
            end else begin
               e = exp_alu.pop_front();
               check("alu_icode", 64'(alu_icode), 64'(e.ic));
               check("alu_ifun",  64'(alu_ifun),  64'(e.fn));
               check("alu_valA",  alu_valA, e.a);
               check("alu_valB",  alu_valB, e.b);
               check("alu_valC",  alu_valC, e.c);
            end
         end
         d_com_q = d_com;
         if (done || err) begin
            ev = (done && err) ? 3 : (done ? EV_DONE : EV_ERR);
            if (exp_evt.size() == 0) check("evt_unexpected", 64'(ev), 64'd0);
            else check("evt_kind", 64'(ev), 64'(exp_evt.pop_front()));
         end
      end
   end

   task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc);
      @(negedge clk);
      icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bench ALU: answer the pending d_com with the given result and check the retire timing.
   task automatic reply(input logic [63:0] ve, input logic c);
      int n = 0;
      while (!d_com && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("d_com_seen", 64'(d_com), 64'd1);
      check("busy_issue", 64'(busy), 64'd1);
      valE = ve; cnd = c; e_com = 1'b1;
      @(negedge clk);
      e_com = 1'b0;
      check("done_pulse", 64'(done), 64'd1);
      check("busy_wb", 64'(busy), 64'd1);
      @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic read_reg(input logic [3:0] id, output logic [63:0] v);
      dbg_reg = id;
      #1;
      v = dbg_val;
   endtask

   task automatic irmov(input logic [3:0] rb, input logic [63:0] v);
      exp_alu.push_back(alu_t'{4'h3, 4'h0, 64'd0, 64'd0, v});
      exp_evt.push_back(EV_DONE);
      issue(4'h3, 4'h0, 4'hF, rb, v);
      reply(v, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int n;
      rst_n = 1'b0; start = 1'b0; icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
      valE = '0; cnd = 1'b0; e_com = 1'b0; dbg_reg = '0;
      #12;
      check("rst_d_com",  64'(d_com),  64'd0);
      check("rst_busy",   64'(busy),   64'd0);
      check("rst_done",   64'(done),   64'd0);
      check("rst_err",    64'(err),    64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_valA",   alu_valA,    64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // irmovq rB=2 valC=7 with an immediate ALU answer: d_com at T1, done at T2.
      exp_alu.push_back(alu_t'{4'h3, 4'h0, 64'd0, 64'd0, 64'd7});
      exp_evt.push_back(EV_DONE);
      issue(4'h3, 4'h0, 4'hF, 4'h2, 64'd7);
      check("d_com_T1", 64'(d_com), 64'd1);
      reply(64'd7, 1'b0);
      read_reg(4'h2, v); check("R2_irmov", v, 64'd7);

      // OPq add R2=1, R3=7.
      irmov(4'h2, 64'd1);
      irmov(4'h3, 64'd7);
      exp_alu.push_back(alu_t'{4'h6, 4'h0, 64'd1, 64'd7, 64'd0});
      exp_evt.push_back(EV_DONE);
      issue(4'h6, 4'h0, 4'h2, 4'h3, 64'd0);
      reply(64'd8, 1'b0);
      read_reg(4'h3, v); check("R3_opq", v, 64'd8);

      // OPq with extreme operands; the overflowed result is stored verbatim.
      irmov(4'h2, 64'h8000_0000_0000_0001);
      irmov(4'h3, 64'hFFFF_FFFF_FFFF_FFFE);
      exp_alu.push_back(alu_t'{4'h6, 4'h0, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0});
      exp_evt.push_back(EV_DONE);
      issue(4'h6, 4'h0, 4'h2, 4'h3, 64'd0);
      reply(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      read_reg(4'h3, v); check("R3_opq_ovf", v, 64'h7FFF_FFFF_FFFF_FFFF);

      // cmov rA=2 rB=4: condition false keeps R4, condition true copies R2.
      irmov(4'h4, 64'd5);
      exp_alu.push_back(alu_t'{4'h2, 4'h3, 64'h8000_0000_0000_0001, 64'd0, 64'd0});
      exp_evt.push_back(EV_DONE);
      issue(4'h2, 4'h3, 4'h2, 4'h4, 64'd0);
      reply(64'h8000_0000_0000_0001, 1'b0);
      read_reg(4'h4, v); check("R4_cmov_nc", v, 64'd5);
      exp_alu.push_back(alu_t'{4'h2, 4'h3, 64'h8000_0000_0000_0001, 64'd0, 64'd0});
      exp_evt.push_back(EV_DONE);
      issue(4'h2, 4'h3, 4'h2, 4'h4, 64'd0);
      reply(64'h8000_0000_0000_0001, 1'b1);
      read_reg(4'h4, v); check("R4_cmov_c", v, 64'h8000_0000_0000_0001);

      // ALU never answers: d_com held exactly 16 cycles, then err and no write.
      exp_alu.push_back(alu_t'{4'h6, 4'h1, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0});
      exp_evt.push_back(EV_ERR);
      issue(4'h6, 4'h1, 4'h2, 4'h3, 64'd0);
      n = 0;
      while (d_com && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("timeout_len", 64'(n), 64'd16);
      check("timeout_err", 64'(err), 64'd1);
      check("timeout_busy", 64'(busy), 64'd0);
      read_reg(4'h3, v); check("R3_timeout", v, 64'h7FFF_FFFF_FFFF_FFFF);

      // Invalid icode, writes to 0xF, nop, then halt.
      exp_evt.push_back(EV_ERR);
      issue(4'h5, 4'h0, 4'h2, 4'h3, 64'd3);
      check("bad_icode_err", 64'(err), 64'd1);
      check("bad_icode_busy", 64'(busy), 64'd0);
      read_reg(4'h3, v); check("R3_bad_icode", v, 64'h7FFF_FFFF_FFFF_FFFF);
      irmov(4'hF, 64'd99);
      read_reg(4'hF, v); check("RF_reads_0", v, 64'd0);
      read_reg(4'h2, v); check("R2_after_RF", v, 64'h8000_0000_0000_0001);
      exp_evt.push_back(EV_DONE);
      issue(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
      check("nop_busy", 64'(busy), 64'd0);
      exp_evt.push_back(EV_DONE);
      issue(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
      check("halted_set", 64'(halted), 64'd1);
      issue(4'h3, 4'h0, 4'hF, 4'h5, 64'd3);
      repeat (3) @(negedge clk);
      check("halted_d_com", 64'(d_com), 64'd0);
      check("halted_busy", 64'(busy), 64'd0);
      read_reg(4'h5, v); check("R5_ignored", v, 64'd0);

      // Reset clears halt; then reset again mid-transaction wipes everything.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("halted_cleared", 64'(halted), 64'd0);
      irmov(4'h6, 64'h55);
      read_reg(4'h6, v); check("R6_before_rst", v, 64'h55);
      exp_alu.push_back(alu_t'{4'h6, 4'h0, 64'h55, 64'h55, 64'd0});
      issue(4'h6, 4'h0, 4'h6, 4'h6, 64'd0);
      repeat (2) @(negedge clk);
      check("pre_rst_d_com", 64'(d_com), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_d_com", 64'(d_com), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 15; i++) begin
         read_reg(4'(i), v);
         check("mid_rst_reg", v, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("alu_queue_empty", 64'(exp_alu.size()), 64'd0);
      check("evt_queue_empty", 64'(exp_evt.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
